// File: rtl/block_stats_streamer.sv
// block_stats_streamer: captures pixel blocks into a two-bank ping-pong buffer,
// computes per-block mean/variance, then replays each block on consecutive
// cycles behind a one-cycle stats_ready pulse.
// Optional frame noise estimate (minimum block variance per frame) is built
// only when the macro STATS_NOISE_EST_EN is defined.
module block_stats_streamer #(
  parameter int DATA_WIDTH    = 8,
  parameter int TOTAL_SAMPLES = 64,
  parameter int LOG2_SAMPLES  = $clog2(TOTAL_SAMPLES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [31:0]               blocks_per_frame,
  output logic                      stats_ready,
  output logic [2*DATA_WIDTH-1:0]   mean_of_block,
  output logic [2*DATA_WIDTH-1:0]   variance_of_block,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      valid_out,
  output logic [2*DATA_WIDTH-1:0]   noise_variance,
  output logic                      noise_valid,
  output logic                      frame_done
);

  localparam int SUM_W = DATA_WIDTH + LOG2_SAMPLES;
  localparam int SQ_W  = 2*DATA_WIDTH + LOG2_SAMPLES;
  localparam int OUT_W = 2*DATA_WIDTH;
  localparam logic [LOG2_SAMPLES-1:0] LAST_IDX = LOG2_SAMPLES'(TOTAL_SAMPLES - 1);
  localparam logic [LOG2_SAMPLES-1:0] PTR_ZERO = LOG2_SAMPLES'(0);
  localparam logic [LOG2_SAMPLES-1:0] PTR_ONE  = LOG2_SAMPLES'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FINISH = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Pixel storage: two banks of one block each
  logic [DATA_WIDTH-1:0] mem_r [0:1][0:TOTAL_SAMPLES-1];

  // Write side
  logic                    wr_bank_r;
  logic [LOG2_SAMPLES-1:0] wr_ptr_r;
  logic [SUM_W-1:0]        sum_r;
  logic [SUM_W-1:0]        sum_nxt_s;
  logic [SQ_W-1:0]         sumsq_r;
  logic [SQ_W-1:0]         sumsq_nxt_s;
  logic [OUT_W-1:0]        sq_s;
  logic [SUM_W-1:0]        bank_sum_r   [0:1];
  logic [SQ_W-1:0]         bank_sumsq_r [0:1];
  logic [1:0]              bank_full_r;
  logic [1:0]              bank_full_nxt_s;
  logic [1:0]              bank_last_r;
  logic [1:0]              fill_s;
  logic [1:0]              free_s;
  logic [1:0]              full_soon_s;
  logic [31:0]             in_cnt_r;
  logic [31:0]             bpf_r;
  logic                    frame_start_r;
  logic                    block_last_s;
  logic                    accept_s;
  logic                    fill_done_s;

  // Read side / FSM
  state_t                  state_r;
  state_t                  next_state_s;
  logic                    rd_bank_r;
  logic                    rd_bank_nxt_s;
  logic [LOG2_SAMPLES-1:0] rd_ptr_r;
  logic [LOG2_SAMPLES-1:0] rd_ptr_nxt_s;
  logic                    last_rd_s;
  logic                    stream_nxt_s;
  logic [DATA_WIDTH-1:0]   data_nxt_s;
  logic                    frame_done_nxt_s;

  // Statistics of the bank about to be replayed
  logic [DATA_WIDTH-1:0]   mean_s;
  logic [OUT_W-1:0]        msq_s;
  logic [OUT_W-1:0]        mean_sq_s;
  logic [OUT_W-1:0]        var_s;

  assign accept_s     = valid_in & ready_in;
  assign fill_done_s  = accept_s & (wr_ptr_r == LAST_IDX);
  assign sq_s         = {{DATA_WIDTH{1'b0}}, data_in} * {{DATA_WIDTH{1'b0}}, data_in};
  assign sum_nxt_s    = sum_r + {{LOG2_SAMPLES{1'b0}}, data_in};
  assign sumsq_nxt_s  = sumsq_r + {{LOG2_SAMPLES{1'b0}}, sq_s};
  assign block_last_s = ((in_cnt_r + 32'd1) == bpf_r);
  assign last_rd_s    = (state_r == ST_STREAM) && (rd_ptr_r == LAST_IDX);

  // A freed bank and a filled bank are always different banks, so the free
  // and the fill can be merged without priority concerns.
  assign fill_s          = {2{fill_done_s}} & {wr_bank_r, ~wr_bank_r};
  assign free_s          = {2{last_rd_s}} & {rd_bank_r, ~rd_bank_r};
  assign bank_full_nxt_s = (bank_full_r & ~free_s) | fill_s;
  assign full_soon_s     = bank_full_r | fill_s;

  assign mean_s    = bank_sum_r[rd_bank_r][SUM_W-1:LOG2_SAMPLES];
  assign msq_s     = bank_sumsq_r[rd_bank_r][SQ_W-1:LOG2_SAMPLES];
  assign mean_sq_s = {{DATA_WIDTH{1'b0}}, mean_s} * {{DATA_WIDTH{1'b0}}, mean_s};
  assign var_s     = (msq_s >= mean_sq_s) ? (msq_s - mean_sq_s) : {OUT_W{1'b0}};

  // Store each accepted pixel into the current write bank
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_bank_r][wr_ptr_r] <= data_in;
    end
  end

  // Write pointer, accumulators, bank bookkeeping and frame tracking on input
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_r       <= 1'b0;
      wr_ptr_r        <= PTR_ZERO;
      sum_r           <= {SUM_W{1'b0}};
      sumsq_r         <= {SQ_W{1'b0}};
      bank_sum_r[0]   <= {SUM_W{1'b0}};
      bank_sum_r[1]   <= {SUM_W{1'b0}};
      bank_sumsq_r[0] <= {SQ_W{1'b0}};
      bank_sumsq_r[1] <= {SQ_W{1'b0}};
      bank_full_r     <= 2'b00;
      bank_last_r     <= 2'b00;
      in_cnt_r        <= 32'd0;
      bpf_r           <= 32'd1;
      frame_start_r   <= 1'b1;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      if (accept_s) begin
        if (frame_start_r) begin
          bpf_r         <= (blocks_per_frame == 32'd0) ? 32'd1 : blocks_per_frame;
          frame_start_r <= 1'b0;
        end
        if (wr_ptr_r == LAST_IDX) begin
          bank_sum_r[wr_bank_r]   <= sum_nxt_s;
          bank_sumsq_r[wr_bank_r] <= sumsq_nxt_s;
          bank_last_r[wr_bank_r]  <= block_last_s;
          sum_r                   <= {SUM_W{1'b0}};
          sumsq_r                 <= {SQ_W{1'b0}};
          wr_ptr_r                <= PTR_ZERO;
          wr_bank_r               <= ~wr_bank_r;
          if (block_last_s) begin
            in_cnt_r      <= 32'd0;
            frame_start_r <= 1'b1;
          end else begin
            in_cnt_r <= in_cnt_r + 32'd1;
          end
        end else begin
          sum_r    <= sum_nxt_s;
          sumsq_r  <= sumsq_nxt_s;
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: banks are replayed in the same alternating order they fill
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (full_soon_s[rd_bank_r]) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FINISH: begin
        next_state_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (!last_rd_s) begin
          next_state_s = ST_STREAM;
        end else if (full_soon_s[~rd_bank_r]) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: next read position and the values the output registers load
  always_comb begin
    stream_nxt_s = (next_state_s == ST_STREAM);
    if (last_rd_s) begin
      rd_bank_nxt_s = ~rd_bank_r;
    end else begin
      rd_bank_nxt_s = rd_bank_r;
    end
    if ((state_r == ST_STREAM) && !last_rd_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = PTR_ZERO;
    end
    if (stream_nxt_s) begin
      data_nxt_s = mem_r[rd_bank_nxt_s][rd_ptr_nxt_s];
    end else begin
      data_nxt_s = {DATA_WIDTH{1'b0}};
    end
    frame_done_nxt_s = stream_nxt_s && (rd_ptr_nxt_s == LAST_IDX) && bank_last_r[rd_bank_nxt_s];
  end

  // Read position and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_r         <= 1'b0;
      rd_ptr_r          <= PTR_ZERO;
      ready_in          <= 1'b0;
      valid_out         <= 1'b0;
      data_out          <= {DATA_WIDTH{1'b0}};
      stats_ready       <= 1'b0;
      frame_done        <= 1'b0;
      mean_of_block     <= {OUT_W{1'b0}};
      variance_of_block <= {OUT_W{1'b0}};
    end else begin
      rd_bank_r   <= rd_bank_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      ready_in    <= ~(bank_full_nxt_s[0] & bank_full_nxt_s[1]);
      valid_out   <= stream_nxt_s;
      data_out    <= data_nxt_s;
      stats_ready <= (state_r == ST_FINISH);
      frame_done  <= frame_done_nxt_s;
      if (state_r == ST_FINISH) begin
        mean_of_block     <= {{DATA_WIDTH{1'b0}}, mean_s};
        variance_of_block <= var_s;
      end
    end
  end

`ifdef STATS_NOISE_EST_EN
  logic [OUT_W-1:0] min_var_r;

  // Track the minimum block variance of the frame and publish it at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      min_var_r      <= {OUT_W{1'b1}};
      noise_variance <= {OUT_W{1'b0}};
      noise_valid    <= 1'b0;
    end else begin
      noise_valid <= frame_done_nxt_s;
      if (frame_done_nxt_s) begin
        noise_variance <= min_var_r;
        min_var_r      <= {OUT_W{1'b1}};
      end else if ((state_r == ST_FINISH) && (var_s < min_var_r)) begin
        min_var_r <= var_s;
      end
    end
  end
`else
  assign noise_variance = {OUT_W{1'b0}};
  assign noise_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_block_stats_streamer.sv
// Self-checking bench for block_stats_streamer: an input monitor feeds a
// block-level reference model into scoreboard queues; an output monitor pops
// and compares replayed pixels, statistics, timing and frame pulses.
module tb_block_stats_streamer;

  localparam int DW = 8;
  localparam int N  = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = 8'h00;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [31:0]   blocks_per_frame = 32'd1;
  logic          stats_ready;
  logic [15:0]   mean_of_block;
  logic [15:0]   variance_of_block;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [15:0]   noise_variance;
  logic          noise_valid;
  logic          frame_done;

  block_stats_streamer #(.DATA_WIDTH(DW), .TOTAL_SAMPLES(N)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .blocks_per_frame(blocks_per_frame), .stats_ready(stats_ready),
    .mean_of_block(mean_of_block), .variance_of_block(variance_of_block),
    .data_out(data_out), .valid_out(valid_out), .noise_variance(noise_variance),
    .noise_valid(noise_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int mean_v;
    int var_v;
    bit last_f;
    int exp_cyc;
  } blk_t;

  // Scoreboard and reference-model state
  blk_t          blk_q[$];
  logic [DW-1:0] pix_q[$];
  logic [DW-1:0] cur_in[$];
  blk_t          cur;
  int  frame_blk_m = 0;
  int  bpf_m = 1;
  bit  frame_start_m = 1'b1;
  int  in_blocks = 0;
  int  out_blocks = 0;
  int  out_idx = 0;
  int  held_mean = 0;
  int  held_var = 0;
  int  min_m = 16'hFFFF;
  int  last_end_cyc = -100;
  bit  zero_chk = 1'b0;

  // Monitor: sample away from the active edge; outputs first, then inputs
  always @(negedge clk) begin
    if (rst) begin
      blk_q.delete(); pix_q.delete(); cur_in.delete();
      frame_blk_m = 0; frame_start_m = 1'b1; in_blocks = 0; out_blocks = 0;
      out_idx = 0; held_mean = 0; held_var = 0; min_m = 16'hFFFF; zero_chk = 1'b1;
    end else if (zero_chk) begin
      zero_chk = 1'b0;
      chk("reset_outputs", {ready_in, stats_ready, valid_out, frame_done, noise_valid,
          mean_of_block, variance_of_block, data_out, noise_variance}, 64'd0);
    end else begin
      logic fd_exp;
      chk("ready_in", ready_in, (in_blocks - out_blocks) < 2);
      chk("stats_ready", stats_ready, valid_out && (out_idx == 0));
      if (out_idx > 0) chk("valid_contiguous", valid_out, 1'b1);
      if (valid_out && out_idx == 0) begin
        chk("block_expected", blk_q.size() > 0, 1'b1);
        if (blk_q.size() > 0) begin
          cur = blk_q.pop_front();
          held_mean = cur.mean_v;
          held_var = cur.var_v;
          if (cur.exp_cyc >= 0) chk("latency", cyc, cur.exp_cyc);
          else chk("replay_gap", cyc <= last_end_cyc + 2, 1'b1);
          if (cur.var_v < min_m) min_m = cur.var_v;
        end
      end
      chk("mean_of_block", mean_of_block, held_mean);
      chk("variance_of_block", variance_of_block, held_var);
      fd_exp = valid_out && (out_idx == N - 1) && cur.last_f;
      chk("frame_done", frame_done, fd_exp);
`ifdef STATS_NOISE_EST_EN
      chk("noise_valid", noise_valid, fd_exp);
      if (fd_exp) begin
        chk("noise_variance", noise_variance, min_m);
        min_m = 16'hFFFF;
      end
`else
      chk("noise_off", {noise_valid, noise_variance}, 17'd0);
`endif
      if (valid_out) begin
        chk("pixel_expected", pix_q.size() > 0, 1'b1);
        if (pix_q.size() > 0) chk("data_out", data_out, pix_q.pop_front());
        out_idx++;
        if (out_idx == N) begin
          out_idx = 0;
          out_blocks++;
          last_end_cyc = cyc;
        end
      end
      // Input side: reference model of a block, built when it completes
      if (valid_in && ready_in) begin
        if (frame_start_m) begin
          bpf_m = (blocks_per_frame == 32'd0) ? 1 : int'(blocks_per_frame);
          frame_start_m = 1'b0;
        end
        cur_in.push_back(data_in);
        pix_q.push_back(data_in);
        if (cur_in.size() == N) begin
          blk_t b;
          int s, sq, msq, p;
          s = 0; sq = 0;
          foreach (cur_in[i]) begin
            p = int'(cur_in[i]);
            s += p;
            sq += p * p;
          end
          b.mean_v = s / N;
          msq = sq / N;
          b.var_v = msq - b.mean_v * b.mean_v;
          if (b.var_v < 0) b.var_v = 0;
          b.last_f = (frame_blk_m + 1 == bpf_m);
          frame_blk_m = b.last_f ? 0 : frame_blk_m + 1;
          if (b.last_f) frame_start_m = 1'b1;
          b.exp_cyc = (in_blocks == out_blocks) ? cyc + 2 : -1;
          in_blocks++;
          blk_q.push_back(b);
          cur_in.delete();
        end
      end
    end
  end

  // Drive one pixel and hold it until the DUT accepts it
  task automatic send_pixel(input logic [DW-1:0] p);
    int guard;
    guard = 0;
    data_in = p;
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_in && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_in) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready_in stayed 0 for %0d cycles", guard);
    end
    @(posedge clk);
    #1;
  endtask

  // kind: 0 constant 0x80, 1 alternating 00/FF, 2 ramp, 3 random
  task automatic send_block(input int kind, input int gap_pct);
    logic [DW-1:0] p;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0: p = 8'h80;
        1: p = (i % 2 == 1) ? 8'hFF : 8'h00;
        2: p = 8'(i);
        default: p = 8'($urandom_range(0, 255));
      endcase
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        valid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      send_pixel(p);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    valid_in = 1'b0;
    while ((pix_q.size() != 0 || cur_in.size() != 0) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d pixels still expected", pix_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    blocks_per_frame = 32'd1;
    send_block(0, 0); drain();
    send_block(1, 0); drain();
    send_block(2, 0); drain();

    blocks_per_frame = 32'd3;
    send_block(3, 0); send_block(3, 0); send_block(3, 0); drain();

    // Reset in the middle of a replay
    blocks_per_frame = 32'd1;
    send_block(0, 0);
    valid_in = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!stats_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!stats_ready) begin
      checks++; errors++;
      $display("FAIL wait_stats_ready: no pulse within %0d cycles", guard);
    end
    repeat (20) @(posedge clk);
    #1;
    pulse_reset();
    @(posedge clk);
    #1;
    send_block(0, 0); drain();

    // Two-block frame for the noise estimate
    blocks_per_frame = 32'd2;
    send_block(1, 0); send_block(2, 0); drain();

    // Random blocks, random input gaps, frame sizes including 0
    for (int k = 0; k < 6; k++) begin
      blocks_per_frame = 32'($urandom_range(0, 3));
      send_block(3, 25);
    end
    drain();

    chk("scoreboard_empty", pix_q.size() + blk_q.size() + cur_in.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_stats_streamer.md
Name: block_stats_streamer

Overview:
- Producer-side partner of wiener_calc: turns a raw pixel stream into per-block statistics plus a time-aligned replay of the same pixels.
- Accumulates each block of TOTAL_SAMPLES pixels and computes the block mean and variance.
- Then asserts a one-cycle stats_ready and replays the buffered pixels on consecutive cycles, which is the timing wiener_calc expects.
- A two-bank ping-pong buffer lets the next block be captured while the current block is replayed.

Parameters:
- DATA_WIDTH, 8: pixel width.
- TOTAL_SAMPLES, 64: pixels per block; power of two, at least 4.
- LOG2_SAMPLES, $clog2(TOTAL_SAMPLES): derived shift amount; not to be overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  DATA_WIDTH  pixel from upstream.
- valid_in  in  1  data_in is valid.
- ready_in  out  1  block can accept a pixel; a transfer occurs when valid_in && ready_in.
- blocks_per_frame  in  32  number of blocks in a frame; sampled at the first accepted pixel of each frame.
- stats_ready  out  1  one-cycle pulse marking the first replayed pixel of a block.
- mean_of_block  out  2*DATA_WIDTH  block mean, zero-extended; held until the next stats_ready.
- variance_of_block  out  2*DATA_WIDTH  block variance; held until the next stats_ready.
- data_out  out  DATA_WIDTH  replayed pixel.
- valid_out  out  1  data_out is valid.
- noise_variance  out  2*DATA_WIDTH  frame noise estimate (optional feature).
- noise_valid  out  1  one-cycle pulse when noise_variance updates.
- frame_done  out  1  one-cycle pulse with the last replayed pixel of a frame.

Behaviour:
- Reset:
  - All outputs 0.
  - ready_in becomes 1 the cycle after rst deasserts.
  - Both banks marked empty; all counters 0.
  - Reset mid-block or mid-replay discards all partial data.
- Input side:
  - The write pointer fills the current write bank.
  - sum is DATA_WIDTH+LOG2_SAMPLES bits; sumsq is 2*DATA_WIDTH+LOG2_SAMPLES bits; both accumulate on every accepted pixel.
  - On sample TOTAL_SAMPLES-1: the bank is marked full, the write side swaps to the other bank, and sum/sumsq are latched into per-bank registers and then cleared.
  - ready_in = 0 only while both banks are full. No pixel is ever dropped.
- Statistics (one register stage after a bank fills, in FINISH):
  - mean = sum >> LOG2_SAMPLES (truncate).
  - msq = sumsq >> LOG2_SAMPLES.
  - var = msq - mean*mean, clamped to 0 if negative.
  - Upper bits of mean_of_block are 0.
- Output FSM states:
  - IDLE -> FINISH when any bank is full and has no computed statistics.
  - FINISH -> STREAM after 1 cycle (statistics registered).
  - STREAM: on the first cycle, stats_ready=1, mean/variance outputs update, valid_out=1, data_out=pixel 0. valid_out stays 1 for exactly TOTAL_SAMPLES consecutive cycles; there is no output backpressure.
  - After the last pixel the bank is freed. Go to FINISH if the other bank is full, otherwise IDLE.
- Latency and throughput:
  - Last input pixel accepted at cycle T -> stats_ready at T+2 when the FSM is IDLE.
  - Back-to-back blocks: gap of at most 1 cycle (FINISH) between replays.
- Frame boundary:
  - A block counter increments on each replay end.
  - When it equals blocks_per_frame: frame_done pulses with the last pixel and the counter wraps to 0.
  - blocks_per_frame=0 is treated as 1.
- Simultaneous events:
  - A bank freed and a bank filled in the same cycle: the free takes effect first, so ready_in stays 1.

Optional Feature:
- Macro: STATS_NOISE_EST_EN.
- Defined:
  - Track the minimum variance_of_block over the frame.
  - At frame_done, noise_variance updates to that minimum and noise_valid pulses in the same cycle.
  - The minimum is reset to all-ones for the next frame.
- Undefined: noise_variance and noise_valid are tied to 0; no minimum tracker is built.

Test Plan:
- Constant block: 64 pixels of 0x80, blocks_per_frame=1 -> stats_ready 2 cycles after the last pixel; mean 0x0080, variance 0x0000; data_out 0x80 for 64 cycles; frame_done with the last one.
- Alternating 0x00/0xFF, 64 pixels -> mean 0x007F, variance 0x3FFF; replay order identical to input.
- Ramp 0..63 -> mean 0x001F, variance 0x0174.
- Three blocks streamed with valid_in always 1:
  - ready_in drops exactly while both banks are full.
  - No pixel is lost or duplicated.
  - Replays are separated by a gap of at most 1 cycle.
- rst pulse on cycle 20 of a replay -> all outputs 0 next cycle; a fresh constant block then yields correct statistics.
- With STATS_NOISE_EST_EN, blocks_per_frame=2, blocks = alternating then ramp -> noise_variance 0x0174 and noise_valid pulse at frame_done. Without the macro -> noise_variance stays 0.
